// File: rtl/requant_pool_stream_pkg.sv
// Shared requant/saturate and signed-max helpers plus LeNet layer geometry.
// Pure functions and constants only; no timing or flow control.
package requant_pool_stream_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ACC_W = 21;
  localparam int DEF_SHIFT = 13;

  localparam int L2_W = 24;
  localparam int L2_H = 24;
  localparam int L2_C = 6;

  localparam int L4_W = 8;
  localparam int L4_H = 8;
  localparam int L4_C = 16;

  // Arithmetic shift then clamp to the signed WIDTH range (or [0, max] with ReLU).
  function automatic logic signed [31:0] requant(input logic signed [63:0] acc,
                                                 input int shift,
                                                 input int width,
                                                 input logic relu);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = relu ? 64'sd0 : -(64'sd1 <<< (width - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return 32'(s);
  endfunction

  function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/requant_pool_stream_linebuf.sv
// Pooling line buffer: one write port, one combinational read port, no reset.
// Write lands on the clock edge; read is same-cycle; no flow control.
module pool_linebuf #(
  parameter int DEPTH = 72,
  parameter int WIDTH = 8,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/requant_pool_stream.sv
// Requantise conv accumulators to WIDTH bits and 2x2 max-pool a (row, col, ch) stream.
// Latency 1 cycle from the odd-row/odd-col beat; in_ready = !out_valid || out_ready.
module requant_pool_stream
  import requant_pool_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int W     = L2_W,
  parameter int H     = L2_H,
  parameter int C     = L2_C,
  parameter int RELU  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    frame_err
);

  localparam int CW    = (C > 1) ? $clog2(C) : 1;
  localparam int XW    = (W > 1) ? $clog2(W) : 1;
  localparam int YW    = (H > 1) ? $clog2(H) : 1;
  localparam int DEPTH = (W / 2) * C;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] CH_MAX  = CW'(C - 1);
  localparam logic [XW-1:0] COL_MAX = XW'(W - 1);
  localparam logic [YW-1:0] ROW_MAX = YW'(H - 1);

  logic [CW-1:0] ch;
  logic [XW-1:0] col;
  logic [YW-1:0] row;

  logic signed [WIDTH-1:0] hreg [C];
  logic signed [31:0]      q_full;
  logic signed [WIDTH-1:0] q;
  logic signed [WIDTH-1:0] h;
  logic signed [WIDTH-1:0] lb_rd;
  logic signed [WIDTH-1:0] pooled;
  logic [AW-1:0]           lb_addr;
  logic                    fire_in;
  logic                    at_end;
  logic                    lb_wr;
  logic                    emit;

  assign in_ready = !out_valid || out_ready;
  assign fire_in  = in_valid && in_ready;
  assign at_end   = (row == ROW_MAX) && (col == COL_MAX) && (ch == CH_MAX);

  assign q_full  = requant(64'(in_data), SHIFT, WIDTH, RELU == 1);
  assign q       = WIDTH'(q_full);
  assign h       = WIDTH'(smax(32'(hreg[ch]), 32'(q)));
  assign pooled  = WIDTH'(smax(32'(lb_rd), 32'(h)));
  assign lb_addr = AW'((int'(col) >> 1) * C + int'(ch));
  assign lb_wr   = fire_in && col[0] && !row[0];
  assign emit    = fire_in && col[0] && row[0];

  // Horizontal partial max waits here for the odd-column partner of the same channel.
  always_ff @(posedge clk) begin
    if (fire_in && !col[0]) begin
      hreg[ch] <= q;
    end
  end

  pool_linebuf #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_linebuf (
    .clk     (clk),
    .wr_en   (lb_wr),
    .wr_addr (lb_addr),
    .wr_data (h),
    .rd_addr (lb_addr),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch  <= '0;
      col <= '0;
      row <= '0;
    end else if (fire_in) begin
      if (in_last && !at_end) begin
        // Early in_last: resynchronise to the start of a frame.
        ch  <= '0;
        col <= '0;
        row <= '0;
      end else if (ch == CH_MAX) begin
        ch <= '0;
        if (col == COL_MAX) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        ch <= ch + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (fire_in && (in_last != at_end)) begin
      frame_err <= 1'b1;
    end
  end

  // A new beat can only load when the slot is empty or draining this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= pooled;
      out_last  <= at_end && in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_requant_pool_stream.sv
// Directed bench for requant_pool_stream on 4x4 frames (C=1 ReLU and C=2 signed).
module tb_requant_pool_stream;

  localparam int WIDTH = 8;
  localparam int ACC_W = 21;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                    a_in_valid, a_in_ready, a_in_last;
  logic signed [ACC_W-1:0] a_in_data;
  logic                    a_out_valid, a_out_ready, a_out_last, a_frame_err;
  logic signed [WIDTH-1:0] a_out_data;

  logic                    b_in_valid, b_in_ready, b_in_last;
  logic signed [ACC_W-1:0] b_in_data;
  logic                    b_out_valid, b_out_ready, b_out_last, b_frame_err;
  logic signed [WIDTH-1:0] b_out_data;

  int errors = 0;
  int checks = 0;

  int a_q[$];
  bit a_lq[$];
  int b_q[$];
  bit b_lq[$];

  requant_pool_stream #(
    .WIDTH(WIDTH), .ACC_W(ACC_W), .SHIFT(0), .W(4), .H(4), .C(1), .RELU(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .frame_err(a_frame_err)
  );

  requant_pool_stream #(
    .WIDTH(WIDTH), .ACC_W(ACC_W), .SHIFT(0), .W(4), .H(4), .C(2), .RELU(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .frame_err(b_frame_err)
  );

  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      a_q.push_back(int'(a_out_data));
      a_lq.push_back(a_out_last);
    end
    if (b_out_valid && b_out_ready) begin
      b_q.push_back(int'(b_out_data));
      b_lq.push_back(b_out_last);
    end
  end

  task automatic drive_beat_a(input int d, input bit l);
    int n;
    a_in_valid = 1'b1;
    a_in_data  = ACC_W'(d);
    a_in_last  = l;
    n = 0;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) begin
      checks++; errors++;
      $display("FAIL drive_a_timeout: in_ready=%0b required 1", a_in_ready);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic drive_beat_b(input int d, input bit l);
    int n;
    b_in_valid = 1'b1;
    b_in_data  = ACC_W'(d);
    b_in_last  = l;
    n = 0;
    @(negedge clk);
    while (!b_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b_in_ready) begin
      checks++; errors++;
      $display("FAIL drive_b_timeout: in_ready=%0b required 1", b_in_ready);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = '0; a_in_last = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_last = 0; b_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", a_out_valid); end
    checks++; if (a_out_data !== 8'sd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", a_out_data); end
    checks++; if (a_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b want 0", a_out_last); end
    checks++; if (a_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b want 0", a_frame_err); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", a_in_ready); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %0b want 0", b_out_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pool();
    int exp_d[4] = '{5, 7, 13, 15};
    bit exp_l[4] = '{0, 0, 0, 1};
    int k;
    a_q.delete(); a_lq.delete();
    k = 0;
    for (int i = 0; i < 16; i++) begin
      drive_beat_a(i, i == 15);
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 8'(exp_d[k])) begin
          errors++;
          $display("FAIL pool_latency beat %0d: valid=%0b data=%0d want valid=1 data=%0d",
                   i, a_out_valid, a_out_data, exp_d[k]);
        end
        k++;
      end
      if (i == 4 || i == 6) begin
        checks++;
        if (a_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL pool_idle beat %0d: valid=%0b want 0", i, a_out_valid);
        end
      end
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (a_q.size() != 4) begin errors++; $display("FAIL pool_count: got %0d want 4", a_q.size()); end
    for (int i = 0; i < 4 && i < a_q.size(); i++) begin
      checks++;
      if (a_q[i] != exp_d[i] || a_lq[i] != exp_l[i]) begin
        errors++;
        $display("FAIL pool_out[%0d]: data=%0d last=%0b want data=%0d last=%0b",
                 i, a_q[i], a_lq[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (a_frame_err !== 1'b0) begin errors++; $display("FAIL pool_frame_err: got %0b want 0", a_frame_err); end
  endtask

  task automatic test_sat_relu();
    int exp_d[4] = '{127, 7, 13, 15};
    a_q.delete(); a_lq.delete();
    for (int i = 0; i < 16; i++) drive_beat_a((i == 5) ? 300 : i, i == 15);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (a_q.size() != 4) begin errors++; $display("FAIL sat_count: got %0d want 4", a_q.size()); end
    for (int i = 0; i < 4 && i < a_q.size(); i++) begin
      checks++;
      if (a_q[i] != exp_d[i]) begin
        errors++;
        $display("FAIL sat_out[%0d]: got %0d want %0d", i, a_q[i], exp_d[i]);
      end
    end
    a_q.delete(); a_lq.delete();
    for (int i = 0; i < 16; i++) drive_beat_a(-5, i == 15);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (a_q.size() != 4) begin errors++; $display("FAIL relu_count: got %0d want 4", a_q.size()); end
    for (int i = 0; i < 4 && i < a_q.size(); i++) begin
      checks++;
      if (a_q[i] != 0) begin
        errors++;
        $display("FAIL relu_out[%0d]: got %0d want 0", i, a_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_d[4] = '{5, 7, 13, 15};
    a_q.delete(); a_lq.delete();
    a_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive_beat_a(i, 1'b0);
    a_in_valid = 1'b1;
    a_in_data  = ACC_W'(6);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 8'sd5 || a_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%0b data=%0d in_ready=%0b want 1/5/0",
                 c, a_out_valid, a_out_data, a_in_ready);
      end
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    for (int i = 6; i < 16; i++) drive_beat_a(i, i == 15);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (a_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", a_q.size()); end
    for (int i = 0; i < 4 && i < a_q.size(); i++) begin
      checks++;
      if (a_q[i] != exp_d[i]) begin
        errors++;
        $display("FAIL bp_out[%0d]: got %0d want %0d", i, a_q[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_channels();
    int exp_d[8] = '{5, 0, 7, -2, 13, -8, 15, -10};
    b_q.delete(); b_lq.delete();
    for (int p = 0; p < 16; p++) begin
      drive_beat_b(p, 1'b0);
      drive_beat_b(-p, p == 15);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (b_q.size() != 8) begin errors++; $display("FAIL ch_count: got %0d want 8", b_q.size()); end
    for (int i = 0; i < 8 && i < b_q.size(); i++) begin
      checks++;
      if (b_q[i] != exp_d[i] || b_lq[i] != (i == 7)) begin
        errors++;
        $display("FAIL ch_out[%0d]: data=%0d last=%0b want data=%0d last=%0b",
                 i, b_q[i], b_lq[i], exp_d[i], (i == 7));
      end
    end
    checks++;
    if (b_frame_err !== 1'b0) begin errors++; $display("FAIL ch_frame_err: got %0b want 0", b_frame_err); end
  endtask

  task automatic test_frame_err();
    int exp_d[4] = '{5, 7, 13, 15};
    a_q.delete(); a_lq.delete();
    for (int i = 0; i < 10; i++) drive_beat_a(i, i == 9);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (a_frame_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0b want 1", a_frame_err); end
    checks++;
    if (a_q.size() != 2 || a_lq[0] != 1'b0 || a_lq[1] != 1'b0) begin
      errors++;
      $display("FAIL err_partial: count=%0d want 2 with last=0", a_q.size());
    end
    a_q.delete(); a_lq.delete();
    for (int i = 0; i < 16; i++) drive_beat_a(i, i == 15);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (a_q.size() != 4) begin errors++; $display("FAIL err_next_count: got %0d want 4", a_q.size()); end
    for (int i = 0; i < 4 && i < a_q.size(); i++) begin
      checks++;
      if (a_q[i] != exp_d[i]) begin
        errors++;
        $display("FAIL err_next_out[%0d]: got %0d want %0d", i, a_q[i], exp_d[i]);
      end
    end
    checks++;
    if (a_frame_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b want 1", a_frame_err); end
  endtask

  task automatic test_reset_mid();
    int exp_d[4] = '{5, 7, 13, 15};
    a_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive_beat_a(i, 1'b0);
    checks++;
    if (a_out_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %0b want 1", a_out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", a_out_valid); end
    checks++;
    if (a_frame_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %0b want 0", a_frame_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    a_q.delete(); a_lq.delete();
    for (int i = 0; i < 16; i++) drive_beat_a(i, i == 15);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (a_q.size() != 4) begin errors++; $display("FAIL mid_count: got %0d want 4", a_q.size()); end
    for (int i = 0; i < 4 && i < a_q.size(); i++) begin
      checks++;
      if (a_q[i] != exp_d[i] || a_lq[i] != (i == 3)) begin
        errors++;
        $display("FAIL mid_out[%0d]: data=%0d last=%0b want data=%0d last=%0b",
                 i, a_q[i], a_lq[i], exp_d[i], (i == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_pool();
    test_sat_relu();
    test_backpressure();
    test_channels();
    test_frame_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/requant_pool_stream.md
REQUANT_POOL_STREAM -- requirements
Module: requant_pool_stream

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 8: output activation width, signed.
- ACC_W, 21: input accumulator width, signed (WIDTH*2+$clog2(C_IN*K*K)).
- SHIFT, 13: arithmetic right shift applied before saturation.
- W, 24: input frame width; SHALL be even.
- H, 24: input frame height; SHALL be even.
- C, 6: channel count.
- RELU, 1: 1 clamps negatives to 0.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block accepts the beat.
- in_data, in, ACC_W: conv accumulator, signed.
- in_last, in, 1: final beat of the frame.
- out_valid, out, 1: pooled beat valid.
- out_ready, in, 1: downstream accepts the beat.
- out_data, out, WIDTH: pooled activation, signed.
- out_last, out, 1: final pooled beat of the frame.
- frame_err, out, 1: sticky in_last misalignment flag.

Function
REQ-003 Input order SHALL be raster with channel innermost (row, col, ch), one channel value per beat; output order SHALL be (row/2, col/2, ch).
REQ-004 A beat SHALL transfer on a rising clk when valid and ready are both high.
REQ-005 Requant: q = sat(in_data >>> SHIFT), saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; if RELU=1 the lower bound SHALL be 0.
REQ-006 For even col the block SHALL store q in hreg[ch]; for odd col it SHALL form h = max(hreg[ch], q), signed compare.
REQ-007 For odd col on an even row, h SHALL be written to linebuf[(col/2)*C+ch] (depth W/2*C, width WIDTH); no output is produced.
REQ-008 For odd col on an odd row, the block SHALL load out_data = max(linebuf[(col/2)*C+ch], h) and set out_valid on the next clk, so latency is 1 cycle.
REQ-009 out_valid SHALL stay high, with out_data/out_last stable, until out_ready; the beat is consumed on out_valid&&out_ready.
REQ-010 in_ready SHALL be !out_valid || out_ready, giving full throughput of 1 beat/cycle with no bubbles.
REQ-011 out_last SHALL be high only with the output for row=H-1, col=W-1, ch=C-1.
REQ-012 The ch, col and row counters SHALL wrap C-1→0, W-1→0 and H-1→0; after the last beat the next accepted beat is (0,0,0).
REQ-013 If in_last is accepted at a position other than (H-1,W-1,C-1), the block SHALL set frame_err and reset its counters to (0,0,0) after that beat.
REQ-014 If the final position is accepted without in_last, the block SHALL set frame_err and wrap normally.
REQ-015 On an in_last misalignment that coincides with an output beat, the block SHALL still emit that beat with out_last=0.
REQ-016 frame_err SHALL clear only on reset.

Reset
REQ-017 Reset SHALL drive out_valid=0, out_data=0, out_last=0 and frame_err=0, and set the counters to (0,0,0); in_ready=1 after reset.
REQ-018 linebuf and hreg SHALL NOT be reset, since every location is written before it is read within a frame.
REQ-019 Reset mid-frame SHALL discard the partial frame and any pending output; the next accepted beat is (0,0,0).

Structure
REQ-020 A shared package SHALL hold the saturate/requant function, a signed max function, and the default parameter constants for the LeNet layers: L2 (W=H=24, C=6) and L4 (W=H=8, C=16).
REQ-021 linebuf SHALL be a separate sub-module, pool_linebuf: 1 write port, 1 read port, combinational read, no reset.
REQ-022 Counters and the output register SHALL live in the top module.

Verification
REQ-023 Using W=H=4, C=1, SHIFT=0, RELU=1, the bench SHALL cover these scenarios:
- Sat/ReLU: in_data=300 → q=127; in_data=-5 → 0.
- Pool: frame values 0..15 in raster order, out_ready=1 → outputs 5, 7, 13, 15; out_last on the 15; each out_valid 1 cycle after its odd-row/odd-col beat.
- Backpressure: out_ready=0 for 3 cycles at the first output → out_valid held at 5, in_ready=0, no beat lost; remaining outputs follow unchanged.
- Channels: C=2, ch1 values negated, RELU=0 → ch0 outputs 5,7,13,15 interleaved with ch1 outputs 0,-2,-8,-10.
- in_last on beat 9 → frame_err=1; the next frame still produces correct outputs 5, 7, 13, 15.
- rst_n low after 6 beats → out_valid=0; a full fresh frame yields 5, 7, 13, 15.
